// File: rtl/glitch_scheduler_if.sv
// Control/status bundle between the campaign controller and the glitch scheduler.
interface glitch_scheduler_if #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned NUM_W = 8
);
  logic             arm;
  logic             abort;
  logic             mode;
  logic [CNT_W-1:0] cfg_delay;
  logic [CNT_W-1:0] cfg_width;
  logic [CNT_W-1:0] cfg_gap;
  logic [NUM_W-1:0] cfg_count;
  logic             enable;
  logic             enable_specific;
  logic             busy;
  logic             done;
  logic [NUM_W-1:0] pulse_cnt;

  modport master (
    output arm, abort, mode, cfg_delay, cfg_width, cfg_gap, cfg_count,
    input  enable, enable_specific, busy, done, pulse_cnt
  );

  modport slave (
    input  arm, abort, mode, cfg_delay, cfg_width, cfg_gap, cfg_count,
    output enable, enable_specific, busy, done, pulse_cnt
  );
endinterface

// File: rtl/glitch_scheduler.sv
// Emits a train of cycle-aligned glitch windows (delay, width, gap, count) towards the
// glitch injector; all outputs come straight from flops so the injector sees clean edges.
module glitch_scheduler #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned NUM_W = 8
) (
  input logic               clk,
  input logic               reset,
  glitch_scheduler_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StDelay, StGlitch, StGap} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] width_q;
  logic [CNT_W-1:0] gap_q;
  logic [NUM_W-1:0] count_q;
  logic [NUM_W-1:0] pulse_cnt_q;
  logic             mode_q;
  logic             enable_q;
  logic             enable_specific_q;
  logic             busy_q;
  logic             done_q;

  logic [CNT_W-1:0] width_eff;
  logic [CNT_W-1:0] gap_eff;
  logic [NUM_W-1:0] pulse_cnt_inc;
  logic             cnt_last;

  // Zero width/gap behave as one cycle so windows never vanish or merge.
  assign width_eff     = (bus.cfg_width == '0) ? CNT_W'(1) : bus.cfg_width;
  assign gap_eff       = (bus.cfg_gap == '0) ? CNT_W'(1) : bus.cfg_gap;
  assign pulse_cnt_inc = pulse_cnt_q + NUM_W'(1);
  assign cnt_last      = (cnt_q == CNT_W'(1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q           <= StIdle;
      cnt_q             <= '0;
      width_q           <= '0;
      gap_q             <= '0;
      count_q           <= '0;
      pulse_cnt_q       <= '0;
      mode_q            <= 1'b0;
      enable_q          <= 1'b0;
      enable_specific_q <= 1'b0;
      busy_q            <= 1'b0;
      done_q            <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q != StIdle && bus.abort) begin
        // Abort keeps pulse_cnt so software can see how far the train got.
        state_q           <= StIdle;
        enable_q          <= 1'b0;
        enable_specific_q <= 1'b0;
        busy_q            <= 1'b0;
      end else begin
        case (state_q)
          StIdle: begin
            if (bus.arm && !bus.abort) begin
              mode_q      <= bus.mode;
              width_q     <= width_eff;
              gap_q       <= gap_eff;
              count_q     <= bus.cfg_count;
              pulse_cnt_q <= '0;
              if (bus.cfg_count == '0) begin
                done_q <= 1'b1;
              end else if (bus.cfg_delay == '0) begin
                state_q           <= StGlitch;
                cnt_q             <= width_eff;
                enable_q          <= !bus.mode;
                enable_specific_q <= bus.mode;
                busy_q            <= 1'b1;
              end else begin
                state_q <= StDelay;
                cnt_q   <= bus.cfg_delay;
                busy_q  <= 1'b1;
              end
            end
          end
          StDelay, StGap: begin
            if (cnt_last) begin
              state_q           <= StGlitch;
              cnt_q             <= width_q;
              enable_q          <= !mode_q;
              enable_specific_q <= mode_q;
            end else begin
              cnt_q <= cnt_q - CNT_W'(1);
            end
          end
          StGlitch: begin
            if (cnt_last) begin
              pulse_cnt_q       <= pulse_cnt_inc;
              enable_q          <= 1'b0;
              enable_specific_q <= 1'b0;
              if (pulse_cnt_inc == count_q) begin
                state_q <= StIdle;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                state_q <= StGap;
                cnt_q   <= gap_q;
              end
            end else begin
              cnt_q <= cnt_q - CNT_W'(1);
            end
          end
          default: begin
            state_q           <= StIdle;
            enable_q          <= 1'b0;
            enable_specific_q <= 1'b0;
            busy_q            <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.enable          = enable_q;
  assign bus.enable_specific = enable_specific_q;
  assign bus.busy            = busy_q;
  assign bus.done            = done_q;
  assign bus.pulse_cnt       = pulse_cnt_q;

endmodule

// File: doc/glitch_scheduler.md
Name: glitch_scheduler

Overview:
- Timing controller that sits directly upstream of the glitch injector and drives its enable / enable_specific inputs.
- Software/testbench arms it with a delay, pulse width, gap and repeat count.
- It then emits a precisely timed train of glitch windows, either random-scramble or specific-value, for fault-injection campaigns on the dual RISC-V core.
- Outputs are registered and glitch-free, so the injector sees clean cycle-aligned windows.

Parameters:
- CNT_W, 16, width of the delay/width/gap counters and config inputs.
- NUM_W, 8, width of the pulse-count config and the pulse counter.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous reset, active-low (0 = reset); sampled on the rising edge of clk.
- arm  input  1  start request; honoured only in IDLE.
- abort  input  1  cancel an in-progress sequence.
- mode  input  1  0 = random glitch (drive enable), 1 = specific-value glitch (drive enable_specific).
- cfg_delay  input  CNT_W  cycles from arm to the first glitch window.
- cfg_width  input  CNT_W  cycles per glitch window.
- cfg_gap  input  CNT_W  low cycles between windows.
- cfg_count  input  NUM_W  number of windows.
- enable  output  1  to injector enable.
- enable_specific  output  1  to injector enable_specific.
- busy  output  1  sequence in progress.
- done  output  1  one-cycle pulse at normal completion.
- pulse_cnt  output  NUM_W  windows completed since last arm.

Behaviour:
- Reset (reset==0 at an edge): state IDLE; enable=0, enable_specific=0, busy=0, done=0, pulse_cnt=0.
  - Reset overrides arm and abort.
  - Reset mid-sequence kills the window on the next edge.
- States: IDLE, DELAY, GLITCH, GAP. All outputs are registered from the next state.
- IDLE, arm=1 at edge E:
  - Latch mode and all cfg_* values; clear pulse_cnt.
  - Later changes to cfg_*/mode have no effect until the next arm.
  - cfg_count==0: stay IDLE, pulse done in cycle E+1, busy stays 0.
  - cfg_delay==0: next state GLITCH.
  - Otherwise: next state DELAY with counter = cfg_delay.
- DELAY: lasts exactly cfg_delay cycles, then GLITCH.
- GLITCH:
  - Lasts exactly max(cfg_width,1) cycles; width 0 is treated as 1.
  - enable=1 if mode==0, else enable_specific=1. Never both high in the same cycle.
  - At window end pulse_cnt increments.
  - If pulse_cnt reaches cfg_count: next state IDLE and done=1 for one cycle.
  - Otherwise: next state GAP.
- GAP: lasts max(cfg_gap,1) cycles with both enables 0, then GLITCH. Gap 0 is treated as 1 so windows stay distinct.
- First window timing: arm sampled at edge 0 → first window occupies cycles 1+D .. D+W, where D=cfg_delay and W=max(cfg_width,1).
- busy=1 in every non-IDLE cycle. done and busy are never high together.
- abort=1 at an edge in a non-IDLE state:
  - Next cycle: IDLE, both enables 0, busy=0, done=0.
  - pulse_cnt holds its value.
  - abort in IDLE has no effect.
  - abort and arm together in IDLE: abort wins and the sequence does not start.
- arm while busy is ignored.
- arm in the same cycle as done (already IDLE) starts a new sequence normally.
- Counters are down-counters of CNT_W bits; they never wrap, because the load value is ≥1 and they reload on every state entry.
- pulse_cnt saturates at cfg_count, which is ≤ 2^NUM_W−1.

Test Plan:
1. Reset: hold reset=0 for 3 cycles with arm=1, then release → all outputs stay 0, state IDLE, no window.
2. arm at cycle 0 with D=3, W=2, G=4, N=3, mode=0:
   - enable=1 in cycles 4-5, 10-11 and 16-17; enable_specific=0 throughout.
   - busy=1 in cycles 1-17; done=1 only in cycle 18.
   - pulse_cnt reaches 3.
3. mode=1, D=0, W=0, G=0, N=2 → enable_specific=1 in cycles 1 and 3, enable never high, done=1 in cycle 4.
4. N=0 → no window, busy never high, done=1 in cycle 1.
5. Abort and late config: D=2, W=5, N=1.
   - abort asserted in cycle 4 (mid-window) → enable drops to 0 from cycle 5, busy=0 in cycle 5, done never pulses, pulse_cnt=0.
   - Separately, changing cfg_width during a run does not alter the window length.
6. Re-arm and reset during a run:
   - arm pulsed repeatedly while busy → only one sequence runs.
   - reset=0 in cycle 5 of a 10-cycle window → enable=0 from cycle 6, all outputs at reset values.
